// File: rtl/decode_stage.sv
// RV32I/RV64I decode stage: each accepted {instr, pc} is decoded in one cycle
// and buffered as a bundle in a DEPTH-entry FIFO, with flush and illegal flagging.
module decode_stage #(
    parameter int XLEN      = 32,
    parameter int DEPTH     = 2,
    parameter bit SUPPORT_M = 1'b0
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            instr_i,
    input  logic [XLEN-1:0]        pc_i,
    input  logic                   flush_i,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [9:0]             family_o,
    output logic [2:0]             funct3_o,
    output logic                   iop_o,
    output logic [XLEN-1:0]        imm_o,
    output logic [4:0]             rs1_o,
    output logic [4:0]             rs2_o,
    output logic [4:0]             rd_o,
    output logic [XLEN-1:0]        pc_o,
    output logic                   illegal_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    localparam int F_LUI     = 0;
    localparam int F_AUIPC   = 1;
    localparam int F_JAL     = 2;
    localparam int F_JALR    = 3;
    localparam int F_BRANCH  = 4;
    localparam int F_LOAD    = 5;
    localparam int F_STORE   = 6;
    localparam int F_ALU_IMM = 7;
    localparam int F_ALU_REG = 8;
    localparam int F_MUL     = 9;

    localparam logic [6:0] OP_LUI     = 7'b0110111;
    localparam logic [6:0] OP_AUIPC   = 7'b0010111;
    localparam logic [6:0] OP_JAL     = 7'b1101111;
    localparam logic [6:0] OP_JALR    = 7'b1100111;
    localparam logic [6:0] OP_BRANCH  = 7'b1100011;
    localparam logic [6:0] OP_LOAD    = 7'b0000011;
    localparam logic [6:0] OP_STORE   = 7'b0100011;
    localparam logic [6:0] OP_ALU_IMM = 7'b0010011;
    localparam logic [6:0] OP_ALU_REG = 7'b0110011;

    typedef struct packed {
        logic [9:0]      family;
        logic [2:0]      funct3;
        logic            iop;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] pc;
        logic            illegal;
    } bundle_t;

    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic signed [31:0] imm_u, imm_j, imm_b, imm_s, imm_i;
    logic              shamt_hi_bad;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];

    assign imm_u = {instr_i[31:12], 12'b0};
    assign imm_j = {{12{instr_i[31]}}, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
    assign imm_b = {{20{instr_i[31]}}, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
    assign imm_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};

    // On RV32 the shift amount is only five bits wide, so instr[25] must be clear.
    assign shamt_hi_bad = (XLEN == 32) && instr_i[25];

    logic [9:0]         fam;
    logic signed [31:0] imm32;
    logic               use_rs1, use_rs2, use_rd, use_f3, iop, bad;
    bundle_t            dec;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
        fam     = '0;
        imm32   = '0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        use_rd  = 1'b0;
        use_f3  = 1'b0;
        iop     = 1'b0;
        bad     = 1'b0;
        case (opcode)
            OP_LUI:   begin fam[F_LUI] = 1'b1;   imm32 = imm_u; use_rd = 1'b1; end
            OP_AUIPC: begin fam[F_AUIPC] = 1'b1; imm32 = imm_u; use_rd = 1'b1; end
            OP_JAL:   begin fam[F_JAL] = 1'b1;   imm32 = imm_j; use_rd = 1'b1; end
            OP_JALR: begin
                fam[F_JALR] = 1'b1; imm32 = imm_i;
                use_rs1 = 1'b1; use_rd = 1'b1; use_f3 = 1'b1;
                bad = (funct3 != 3'b000);
            end
            OP_BRANCH: begin
                fam[F_BRANCH] = 1'b1; imm32 = imm_b;
                use_rs1 = 1'b1; use_rs2 = 1'b1; use_f3 = 1'b1;
                bad = (funct3[2:1] == 2'b01);
            end
            OP_LOAD: begin
                fam[F_LOAD] = 1'b1; imm32 = imm_i;
                use_rs1 = 1'b1; use_rd = 1'b1; use_f3 = 1'b1;
                bad = (XLEN == 32) ? ((funct3 == 3'b011) || (funct3[2:1] == 2'b11))
                                   : (funct3 == 3'b111);
            end
            OP_STORE: begin
                fam[F_STORE] = 1'b1; imm32 = imm_s;
                use_rs1 = 1'b1; use_rs2 = 1'b1; use_f3 = 1'b1;
                bad = (XLEN == 32) ? (funct3 > 3'b010) : (funct3 > 3'b011);
            end
            OP_ALU_IMM: begin
                fam[F_ALU_IMM] = 1'b1; imm32 = imm_i;
                use_rs1 = 1'b1; use_rd = 1'b1; use_f3 = 1'b1;
                if (funct3 == 3'b001) begin
                    bad = (funct7[6:1] != 6'b000000) || shamt_hi_bad;
                end else if (funct3 == 3'b101) begin
                    bad = ((funct7[6:1] != 6'b000000) && (funct7[6:1] != 6'b010000)) || shamt_hi_bad;
                    iop = instr_i[30];
                end
            end
            OP_ALU_REG: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1; use_f3 = 1'b1;
                if (funct7 == 7'b0000000) begin
                    fam[F_ALU_REG] = 1'b1;
                    iop = instr_i[30];
                end else if (funct7 == 7'b0100000) begin
                    fam[F_ALU_REG] = 1'b1;
                    iop = instr_i[30];
                    bad = (funct3 != 3'b000) && (funct3 != 3'b101);
                end else if ((funct7 == 7'b0000001) && SUPPORT_M) begin
                    fam[F_MUL] = 1'b1;
                end else begin
                    bad = 1'b1;
                end
            end
            default: bad = 1'b1;
        endcase

        // Illegal bundles carry only the pc and the flag; every decoded field is zeroed.
        dec         = '0;
        dec.pc      = pc_i;
        dec.illegal = bad;
        if (!bad) begin
            dec.family = fam;
            dec.funct3 = use_f3 ? funct3 : 3'b000;
            dec.iop    = iop;
            dec.imm    = XLEN'(imm32);
            dec.rs1    = use_rs1 ? instr_i[19:15] : 5'd0;
            dec.rs2    = use_rs2 ? instr_i[24:20] : 5'd0;
            dec.rd     = use_rd  ? instr_i[11:7]  : 5'd0;
        end
    end

    bundle_t          mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push, pop;
    bundle_t          head;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign in_ready  = (count != FULL);
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready && !flush_i;
    assign pop       = out_valid && out_ready && !flush_i;

    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_next(wr_ptr);
            if (pop)  rd_ptr <= ptr_next(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: bundle storage is not reset; a slot is only visible once count says it was written.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= dec;
    end

    assign head = out_valid ? mem[rd_ptr] : '0;

    assign family_o  = head.family;
    assign funct3_o  = head.funct3;
    assign iop_o     = head.iop;
    assign imm_o     = head.imm;
    assign rs1_o     = head.rs1;
    assign rs2_o     = head.rs2;
    assign rd_o      = head.rd;
    assign pc_o      = head.pc;
    assign illegal_o = head.illegal;
    assign count_o   = count;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: a queue-based reference FIFO fed by a table-driven
// decoder model, checked every cycle, plus hand-computed directed expectations.
module tb_decode_stage;

    localparam int XLEN  = 32;
    localparam int DEPTH = 2;

    typedef struct packed {
        logic [9:0]  family;
        logic [2:0]  funct3;
        logic        iop;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic        illegal;
    } bundle_t;

    logic                   clk = 1'b0;
    logic                   reset_n;
    logic                   in_valid, in_ready, flush_i, out_valid, out_ready;
    logic [31:0]            instr_i, pc_i;
    logic [9:0]             family_o;
    logic [2:0]             funct3_o;
    logic                   iop_o, illegal_o;
    logic [31:0]            imm_o, pc_o;
    logic [4:0]             rs1_o, rs2_o, rd_o;
    logic [$clog2(DEPTH):0] count_o;

    logic                   m_valid, m_ready, m_out_valid, m_out_ready, m_flush;
    logic [31:0]            m_instr, m_pc;
    logic [9:0]             m_family;
    logic [2:0]             m_funct3;
    logic                   m_iop, m_illegal;
    logic [31:0]            m_imm, m_pc_o;
    logic [4:0]             m_rs1, m_rs2, m_rd;
    logic [$clog2(DEPTH):0] m_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    decode_stage #(.XLEN(XLEN), .DEPTH(DEPTH), .SUPPORT_M(1'b0)) u_dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .instr_i(instr_i), .pc_i(pc_i), .flush_i(flush_i),
        .out_valid(out_valid), .out_ready(out_ready),
        .family_o(family_o), .funct3_o(funct3_o), .iop_o(iop_o), .imm_o(imm_o),
        .rs1_o(rs1_o), .rs2_o(rs2_o), .rd_o(rd_o), .pc_o(pc_o),
        .illegal_o(illegal_o), .count_o(count_o)
    );

    decode_stage #(.XLEN(XLEN), .DEPTH(DEPTH), .SUPPORT_M(1'b1)) u_dut_m (
        .clk(clk), .reset_n(reset_n), .in_valid(m_valid), .in_ready(m_ready),
        .instr_i(m_instr), .pc_i(m_pc), .flush_i(m_flush),
        .out_valid(m_out_valid), .out_ready(m_out_ready),
        .family_o(m_family), .funct3_o(m_funct3), .iop_o(m_iop), .imm_o(m_imm),
        .rs1_o(m_rs1), .rs2_o(m_rs2), .rd_o(m_rd), .pc_o(m_pc_o),
        .illegal_o(m_illegal), .count_o(m_count)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Reference decode: family chosen by opcode, legality from per-family funct3 masks.
    function automatic bundle_t model(input logic [31:0] w, input logic [31:0] pc, input bit m_ok);
        bundle_t     b;
        int          fam;
        logic [7:0]  f3_ok;
        logic [2:0]  f3;
        logic [31:0] imm;
        bit          r1, r2, rdu, f3u, iop, extra_ok;
        b = '0;
        b.pc = pc;
        f3 = w[14:12];
        fam = -1; f3_ok = 8'hFF; imm = '0; extra_ok = 1'b1;
        r1 = 0; r2 = 0; rdu = 0; f3u = 0; iop = 0;
        case (w[6:0])
            7'b0110111: begin fam = 0; rdu = 1; imm = {w[31:12], 12'b0}; end
            7'b0010111: begin fam = 1; rdu = 1; imm = {w[31:12], 12'b0}; end
            7'b1101111: begin fam = 2; rdu = 1; imm = {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0}; end
            7'b1100111: begin fam = 3; r1 = 1; rdu = 1; f3u = 1; imm = {{20{w[31]}}, w[31:20]}; f3_ok = 8'b0000_0001; end
            7'b1100011: begin fam = 4; r1 = 1; r2 = 1; f3u = 1; imm = {{20{w[31]}}, w[7], w[30:25], w[11:8], 1'b0}; f3_ok = 8'b1111_0011; end
            7'b0000011: begin fam = 5; r1 = 1; rdu = 1; f3u = 1; imm = {{20{w[31]}}, w[31:20]}; f3_ok = 8'b0011_0111; end
            7'b0100011: begin fam = 6; r1 = 1; r2 = 1; f3u = 1; imm = {{20{w[31]}}, w[31:25], w[11:7]}; f3_ok = 8'b0000_0111; end
            7'b0010011: begin
                fam = 7; r1 = 1; rdu = 1; f3u = 1; imm = {{20{w[31]}}, w[31:20]};
                if (f3 == 3'd1) extra_ok = (w[31:25] == 7'b0000000);
                if (f3 == 3'd5) begin
                    extra_ok = (w[31:25] == 7'b0000000) || (w[31:25] == 7'b0100000);
                    iop = w[30];
                end
            end
            7'b0110011: begin
                r1 = 1; r2 = 1; rdu = 1; f3u = 1;
                if (w[31:25] == 7'b0000000) fam = 8;
                else if (w[31:25] == 7'b0100000 && (f3 == 3'd0 || f3 == 3'd5)) begin fam = 8; iop = 1; end
                else if (w[31:25] == 7'b0000001 && m_ok) fam = 9;
            end
            default: ;
        endcase
        if (fam >= 0 && f3_ok[f3] && extra_ok) begin
            b.family[fam] = 1'b1;
            b.funct3 = f3u ? f3 : 3'd0;
            b.iop    = iop;
            b.imm    = imm;
            b.rs1    = r1  ? w[19:15] : 5'd0;
            b.rs2    = r2  ? w[24:20] : 5'd0;
            b.rd     = rdu ? w[11:7]  : 5'd0;
        end else begin
            b.illegal = 1'b1;
        end
        return b;
    endfunction

    bundle_t     q[$];
    bundle_t     exp_head;
    logic [31:0] pop_log[$];
    bit          do_pop, do_push;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q.delete();
        end else if (flush_i) begin
            q.delete();
        end else begin
            do_pop  = (q.size() != 0) && out_ready;
            do_push = in_valid && (q.size() < DEPTH);
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back(model(instr_i, pc_i, 1'b0));
        end
    end

    always @(negedge clk) begin
        check("count", count_o, q.size());
        check("out_valid", out_valid, q.size() != 0);
        check("in_ready", in_ready, q.size() < DEPTH);
        exp_head = (q.size() != 0) ? q[0] : '0;
        check("family", family_o, exp_head.family);
        check("funct3", funct3_o, exp_head.funct3);
        check("iop", iop_o, exp_head.iop);
        check("imm", imm_o, exp_head.imm);
        check("rs1", rs1_o, exp_head.rs1);
        check("rs2", rs2_o, exp_head.rs2);
        check("rd", rd_o, exp_head.rd);
        check("pc", pc_o, exp_head.pc);
        check("illegal", illegal_o, exp_head.illegal);
        if (out_valid && out_ready) pop_log.push_back(pc_o);
    end

    task automatic push_one(input logic [31:0] w, input logic [31:0] p);
        bit acc;
        in_valid = 1'b1; instr_i = w; pc_i = p;
        for (int n = 0; n < 50; n++) begin
            acc = in_ready;
            @(posedge clk); #1;
            if (acc) begin
                in_valid = 1'b0;
                return;
            end
        end
        in_valid = 1'b0;
        total++; bad++;
        $display("FAIL push_timeout: in_ready stayed %0b, required 1", in_ready);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int n = 0; n < 50; n++) begin
            if (!out_valid) return;
            @(posedge clk); #1;
        end
        total++; bad++;
        $display("FAIL drain_timeout: out_valid still %0b, required 0", out_valid);
    endtask

    logic [31:0] table_w [24] = '{
        32'h123450B7, 32'h00001117, 32'h0080006F, 32'hFF5FF0EF, 32'h000080E7, 32'h000090E7,
        32'hFFC12183, 32'h00013183, 32'h00016183, 32'h00014183, 32'h00312223, 32'h00313223,
        32'h00309093, 32'h02009093, 32'h40305093, 32'h00305093, 32'h20305093, 32'h002081B3,
        32'h402081B3, 32'h402091B3, 32'h4020D1B3, 32'h0020A063, 32'h00000000, 32'h0000007F
    };
    logic [31:0] extra_w [5] = '{32'h00209463, 32'h00000001, 32'h0000001B, 32'hFFF00013, 32'h0020C1B3};

    int      base;
    bundle_t em;

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; instr_i = '0; pc_i = '0; flush_i = 1'b0; out_ready = 1'b0;
        m_valid = 1'b0; m_instr = '0; m_pc = '0; m_flush = 1'b0; m_out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_count", count_o, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        @(negedge clk); #2 reset_n = 1'b1;
        @(posedge clk); #1;

        // addi x1,x0,5 at pc 0x100
        push_one(32'h00500093, 32'h100);
        check("addi_family", family_o, 10'h080);
        check("addi_rd", rd_o, 1);
        check("addi_rs1", rs1_o, 0);
        check("addi_imm", imm_o, 32'd5);
        check("addi_funct3", funct3_o, 0);
        check("addi_pc", pc_o, 32'h100);
        drain();
        out_ready = 1'b0;

        // beq x0,x0,-4
        push_one(32'hFE000EE3, 32'h104);
        check("beq_family", family_o, 10'h010);
        check("beq_imm", imm_o, 32'hFFFFFFFC);
        check("beq_rs1", rs1_o, 0);
        check("beq_rs2", rs2_o, 0);
        check("beq_rd", rd_o, 0);
        drain();
        out_ready = 1'b0;

        // mul without the M extension is illegal
        push_one(32'h02208033, 32'h108);
        check("mul_illegal", illegal_o, 1);
        check("mul_family", family_o, 0);
        check("mul_rs1", rs1_o, 0);
        check("mul_pc", pc_o, 32'h108);
        drain();

        foreach (table_w[i]) push_one(table_w[i], 32'h1000 + 32'(i * 4));
        foreach (extra_w[i]) push_one(extra_w[i], 32'h1800 + 32'(i * 4));
        drain();

        // Backpressure: third bundle waits until the head is consumed
        out_ready = 1'b0;
        push_one(32'h00100113, 32'h200);
        push_one(32'h00200193, 32'h204);
        check("full_count", count_o, 2);
        check("full_in_ready", in_ready, 0);
        in_valid = 1'b1; instr_i = 32'h00300213; pc_i = 32'h208;
        repeat (2) @(posedge clk);
        #1;
        check("held_count", count_o, 2);
        base = pop_log.size();
        out_ready = 1'b1;
        push_one(32'h00300213, 32'h208);
        drain();
        check("order_len", pop_log.size() - base, 3);
        if (pop_log.size() >= base + 3) begin
            check("order0", pop_log[base], 32'h200);
            check("order1", pop_log[base+1], 32'h204);
            check("order2", pop_log[base+2], 32'h208);
        end

        // Flush with two buffered and a push in the same cycle
        out_ready = 1'b0;
        push_one(32'h00100113, 32'h280);
        push_one(32'h00200193, 32'h284);
        in_valid = 1'b1; instr_i = 32'h00700393; pc_i = 32'h300; flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0; in_valid = 1'b0;
        check("flush_count", count_o, 0);
        check("flush_out_valid", out_valid, 0);
        base = pop_log.size();
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("flush_no_pop", pop_log.size() - base, 0);

        // Asynchronous reset with two bundles buffered
        out_ready = 1'b0;
        push_one(32'h00100113, 32'h380);
        push_one(32'h00200193, 32'h384);
        check("pre_rst_count", count_o, 2);
        #1 reset_n = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_count", count_o, 0);
        check("arst_in_ready", in_ready, 1);
        @(negedge clk); #2 reset_n = 1'b1;
        @(posedge clk); #1;

        // mul with the M extension
        m_valid = 1'b1; m_instr = 32'h02208033; m_pc = 32'h400;
        @(posedge clk); #1;
        m_valid = 1'b0;
        em = model(32'h02208033, 32'h400, 1'b1);
        check("m_model_family", em.family, 10'h200);
        check("m_family", m_family, 10'h200);
        check("m_rs1", m_rs1, 1);
        check("m_rs2", m_rs2, 2);
        check("m_rd", m_rd, 0);
        check("m_illegal", m_illegal, 0);
        check("m_count", m_count, 1);
        check("m_out_valid", m_out_valid, 1);
        check("m_in_ready", m_ready, 1);
        check("m_funct3", m_funct3, em.funct3);
        check("m_iop", m_iop, em.iop);
        check("m_imm", m_imm, em.imm);
        check("m_pc", m_pc_o, em.pc);
        m_out_ready = 1'b1;
        @(posedge clk); #1;
        check("m_pop", m_out_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
